// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle ALU: single-cycle ops plus iterative mul/div, with
//            a start/busy/done handshake and registered results.
// Revision : 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r2,
  output logic             z,
  output logic             err
);

  localparam logic [5:0] c_op_and   = 6'h00;
  localparam logic [5:0] c_op_or    = 6'h01;
  localparam logic [5:0] c_op_add   = 6'h02;
  localparam logic [5:0] c_op_addu  = 6'h03;
  localparam logic [5:0] c_op_xor   = 6'h04;
  localparam logic [5:0] c_op_sub   = 6'h06;
  localparam logic [5:0] c_op_slt   = 6'h07;
  localparam logic [5:0] c_op_sltu  = 6'h08;
  localparam logic [5:0] c_op_lui   = 6'h09;
  localparam logic [5:0] c_op_sll1  = 6'h0A;
  localparam logic [5:0] c_op_sll2  = 6'h0B;
  localparam logic [5:0] c_op_sll8  = 6'h0C;
  localparam logic [5:0] c_op_srl1  = 6'h0D;
  localparam logic [5:0] c_op_srl2  = 6'h0E;
  localparam logic [5:0] c_op_srl8  = 6'h0F;
  localparam logic [5:0] c_op_sra1  = 6'h10;
  localparam logic [5:0] c_op_sra2  = 6'h11;
  localparam logic [5:0] c_op_sra8  = 6'h12;
  localparam logic [5:0] c_op_multu = 6'h13;
  localparam logic [5:0] c_op_bias  = 6'h14;
  localparam logic [5:0] c_op_mult  = 6'h15;
  localparam logic [5:0] c_op_divu  = 6'h16;
  localparam logic [5:0] c_op_sllv  = 6'h17;
  localparam logic [5:0] c_op_srlv  = 6'h18;
  localparam logic [5:0] c_op_srav  = 6'h19;

  localparam logic [WIDTH-1:0]   c_bias_k = WIDTH'(100);
  localparam logic [SHAMT_W-1:0] c_last   = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t             r_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_a;
  logic               r_neg;
  logic               r_dz;

  logic [WIDTH-1:0]   w_res;
  logic               w_err;
  logic               w_iter;
  logic [SHAMT_W-1:0] w_sh;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fin;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;

  // Single-cycle datapath works straight off the inputs; its result is
  // captured on the same edge that accepts start.
  always_comb begin
    w_res  = '0;
    w_err  = 1'b0;
    w_iter = 1'b0;
    w_sh   = b[SHAMT_W-1:0];
    case (ctrl)
      c_op_and:              w_res = a & b;
      c_op_or:               w_res = a | b;
      c_op_xor:              w_res = a ^ b;
      c_op_add, c_op_addu:   w_res = a + b;
      c_op_sub:              w_res = a - b;
      c_op_slt:              w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      c_op_sltu:             w_res = {{(WIDTH-1){1'b0}}, a < b};
      c_op_lui:              w_res = b << (WIDTH / 2);
      c_op_sll1:             w_res = b << 1;
      c_op_sll2:             w_res = b << 2;
      c_op_sll8:             w_res = b << 8;
      c_op_srl1:             w_res = b >> 1;
      c_op_srl2:             w_res = b >> 2;
      c_op_srl8:             w_res = b >> 8;
      c_op_sra1:             w_res = $signed(b) >>> 1;
      c_op_sra2:             w_res = $signed(b) >>> 2;
      c_op_sra8:             w_res = $signed(b) >>> 8;
      c_op_bias: begin
        if (a > b)      w_res = a - c_bias_k;
        else if (a < b) w_res = a + c_bias_k;
        else            w_res = '0;
      end
      c_op_sllv:             w_res = b << w_sh;
      c_op_srlv:             w_res = b >> w_sh;
      c_op_srav:             w_res = $signed(b) >>> w_sh;
      c_op_multu, c_op_mult, c_op_divu: w_iter = 1'b1;
      default:               w_err = 1'b1;
    endcase
  end

  // Signed multiply runs on magnitudes; -min wraps to 2^(WIDTH-1), which is
  // exactly the right unsigned magnitude.
  assign w_signed = (ctrl == c_op_mult);
  assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_prod     = {w_sum, r_lo[WIDTH-1:1]};
  assign w_prod_fin = r_neg ? -w_prod : w_prod;

  assign w_shift  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_mcand};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_lo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= '0;
      r2      <= '0;
      z       <= 1'b1;
      err     <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_a     <= '0;
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          r_state <= S_IDLE;
          if (start) begin
            if (w_iter) begin
              busy  <= 1'b1;
              r_cnt <= '0;
              r_hi  <= '0;
              r_a   <= a;
              if (ctrl == c_op_divu) begin
                r_mcand <= b;
                r_lo    <= a;
                r_dz    <= (b == '0);
                r_neg   <= 1'b0;
                r_state <= S_DIV;
              end else begin
                r_mcand <= w_mag_a;
                r_lo    <= w_mag_b;
                r_dz    <= 1'b0;
                r_neg   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_state <= S_MUL;
              end
            end else begin
              r    <= w_res;
              r2   <= '0;
              z    <= (w_res == '0);
              err  <= w_err;
              done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_hi  <= w_sum[WIDTH:1];
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r       <= w_prod_fin[WIDTH-1:0];
            r2      <= w_prod_fin[2*WIDTH-1:WIDTH];
            z       <= (w_prod_fin[WIDTH-1:0] == '0);
            err     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_FIN;
          end
        end
        S_DIV: begin
          r_hi  <= w_rem_nx;
          r_lo  <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r       <= r_dz ? '1 : w_quo_nx;
            r2      <= r_dz ? r_a : w_rem_nx;
            z       <= r_dz ? 1'b0 : (w_quo_nx == '0);
            err     <= r_dz;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_FIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Scoreboard bench for alu_seq: directed ops push expectations,
//            a monitor pops and compares on every done pulse.
// Revision : 1.0
// ============================================================================
module tb_alu_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [5:0]       ctrl = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, z, err;
  logic [WIDTH-1:0] r, r2;

  alu_seq #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .r(r), .r2(r2), .z(z), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] r2;
    logic        z;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [31:0] cyc = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".r"},   r,  e.r);
        chk({nm, ".r2"},  r2, e.r2);
        chk({nm, ".z"},   {31'd0, z},   {31'd0, e.z});
        chk({nm, ".err"}, {31'd0, err}, {31'd0, e.err});
        chk({nm, ".cyc"}, cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1; waits (bounded) for busy low, then issues one op.
  task automatic op(input string nm, input logic [5:0] c, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] er, input logic [31:0] er2,
                    input logic ez, input logic eerr, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.wait_busy: got busy=1 expected 0 within 100 cycles", nm);
    end
    start = 1'b1; ctrl = c; a = av; b = bv;
    e.r = er; e.r2 = er2; e.z = ez; e.err = eerr; e.cyc = cyc + lat;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.r",    r,  32'd0);
    chk("rst.r2",   r2, 32'd0);
    chk("rst.z",    {31'd0, z},   32'd1);
    chk("rst.err",  {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle ops, issued back to back.
    op("and",   6'h00, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 0, 0, 0, 1);
    op("or",    6'h01, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 0, 0, 0, 1);
    op("xor",   6'h04, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 0, 0, 0, 1);
    op("addw",  6'h03, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 0, 0, 1);
    op("sub0",  6'h06, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 0, 1, 0, 1);
    op("slt",   6'h07, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 1);
    op("sltu",  6'h08, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1, 0, 1);
    op("lui",   6'h09, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 0, 0, 0, 1);
    op("sll8",  6'h0C, 32'h0000_0000, 32'h0000_0001, 32'h0000_0100, 0, 0, 0, 1);
    op("srl2",  6'h0E, 32'h0000_0000, 32'h8000_0010, 32'h2000_0004, 0, 0, 0, 1);
    op("sra8",  6'h12, 32'h0000_0000, 32'h8000_0000, 32'hFF80_0000, 0, 0, 0, 1);
    op("sra1",  6'h10, 32'h0000_0000, 32'h4000_0002, 32'h2000_0001, 0, 0, 0, 1);
    op("sllv",  6'h17, 32'h0000_0000, 32'h0000_0003, 32'h0000_0018, 0, 0, 0, 1);
    op("srlv",  6'h18, 32'h0000_0000, 32'h8000_0004, 32'h0800_0000, 0, 0, 0, 1);
    op("srav",  6'h19, 32'h0000_0000, 32'h8000_0004, 32'hF800_0000, 0, 0, 0, 1);
    op("srav0", 6'h19, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1);
    op("biaseq", 6'h14, 32'h0000_0037, 32'h0000_0037, 32'h0000_0000, 0, 1, 0, 1);
    op("biasgt", 6'h14, 32'd200, 32'd50, 32'd100, 0, 0, 0, 1);
    op("biaslt", 6'h14, 32'd3,   32'd10, 32'd103, 0, 0, 0, 1);
    op("inv3f", 6'h3F, 32'h1234_5678, 32'h1, 32'h0, 0, 1, 1, 1);
    op("inv05", 6'h05, 32'h1234_5678, 32'h1, 32'h0, 0, 1, 1, 1);

    // Iterative ops.
    op("mult_n3x7",  6'h15, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 0, 33);
    op("mult_min",   6'h15, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1, 0, 33);
    op("multu_max",  6'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0, 33);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("multu.busy_cycles", n, 32'd32);
    op("divu_100_7", 6'h16, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 33);
    op("divu_by0",   6'h16, 32'd9,   32'd0, 32'hFFFF_FFFF, 32'd9, 0, 1, 33);
    op("divu_big",   6'h16, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0, 0, 33);
    op("divu_small", 6'h16, 32'd5, 32'd9, 32'd0, 32'd5, 1, 0, 33);
    op("biasr",      6'h14, 32'd3, 32'd10, 32'd103, 0, 0, 0, 1);

    // Reset during cycle 10 of a MULTU: expectation discarded, no done allowed.
    op("multu_abort", 6'h13, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 0, 0, 33);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    exp_q.delete();
    name_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.r",    r, 32'd0);
    chk("abort.z",    {31'd0, z}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    op("add_after_rst", 6'h02, 32'd5, 32'd7, 32'd12, 0, 0, 0, 1);

    // Start held high: ADD, then MULT in the done cycle, then an ignored ADD.
    op("hs_add", 6'h02, 32'd1, 32'd2, 32'd3, 0, 0, 0, 1);
    start = 1'b1; ctrl = 6'h15; a = 32'hFFFF_FFFE; b = 32'd3;
    e.r = 32'hFFFF_FFFA; e.r2 = 32'hFFFF_FFFF; e.z = 1'b0; e.err = 1'b0; e.cyc = cyc + 33;
    exp_q.push_back(e);
    name_q.push_back("hs_mult");
    @(posedge clk); #1;
    ctrl = 6'h02; a = 32'd40; b = 32'd2;
    repeat (5) @(posedge clk);
    #1;
    chk("hs.busy_during", {31'd0, busy}, 32'd1);
    ctrl = 6'h00;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Executes the existing 6-bit ctrl opcode set at WIDTH bits, and adds iterative signed/unsigned multiply, unsigned divide and variable shifts.
- Uses a start/busy/done handshake with registered results.
- Sits in the EX stage. The pipeline controller stalls on busy and consumes r/r2 (LO/HI) on done.

Parameters:
- WIDTH, 32: operand/result width; even, ≥ 8.
- SHAMT_W, 5: bits of b used as shift amount for variable shifts; must satisfy 2^SHAMT_W == WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous reset, active-high.
- start, input, 1: operation request; sampled only when busy=0.
- ctrl, input, 6: opcode, captured with start.
- a, input, WIDTH: operand s, captured with start.
- b, input, WIDTH: operand t, captured with start.
- busy, output, 1: iterative operation in progress; start ignored while high.
- done, output, 1: one-cycle pulse, r/r2/z/err valid.
- r, output, WIDTH: result / product low / quotient.
- r2, output, WIDTH: product high / remainder; 0 for other ops.
- z, output, 1: 1 when r == 0.
- err, output, 1: invalid opcode or divide by zero; valid with done.

Behaviour:
- Reset (async, any state, including mid-iteration): state IDLE; busy=0, done=0, r=0, r2=0, z=1, err=0. Partial results discarded; no done is produced for the aborted op.
- Operands and opcode are registered at the start edge. Later changes on a/b/ctrl have no effect until the next accepted start.
- Outputs hold their last values until the next done.
- FSM states:
  - IDLE: on start, single-cycle opcode -> stay IDLE, results written at that edge, done=1 next cycle. Iterative opcode -> MUL or DIV, busy=1.
  - MUL: one shift-add step per cycle, WIDTH cycles. Last step -> FIN.
  - DIV: one restoring step per cycle, WIDTH cycles. Last step -> FIN.
  - FIN: write r/r2/z/err, done=1, busy=0 -> IDLE.
- Latency:
  - Single-cycle ops: done in the cycle after start.
  - Iterative ops: done exactly WIDTH+1 cycles after the start cycle; busy high for WIDTH cycles.
- Back-to-back: start may be asserted in the same cycle done is high (busy=0 there) and is accepted.
- Single-cycle opcodes (r2=0):
  - 0x00 AND; 0x01 OR; 0x04 XOR.
  - 0x02 ADD and 0x03 ADDU: modulo 2^WIDTH.
  - 0x06 SUB: modulo 2^WIDTH.
  - 0x07 SLT: signed compare; 0x08 SLTU: unsigned compare; result 1 or 0.
  - 0x09 LUI: t << (WIDTH/2).
  - 0x0A/0x0B/0x0C SLL by 1/2/8; 0x0D/0x0E/0x0F SRL by 1/2/8.
  - 0x10/0x11/0x12 SRA by 1/2/8, sign fill from t[WIDTH-1].
  - 0x14 BIAS: s>t -> s-100; s<t -> s+100; s==t -> 0 (unsigned compare, modulo arithmetic).
  - 0x17 SLLV: t << b[SHAMT_W-1:0]. Note: the shift source for variable shifts is b itself.
  - 0x18 SRLV: logical right shift by b[SHAMT_W-1:0].
  - 0x19 SRAV: arithmetic right shift by b[SHAMT_W-1:0].
  - Shift amount 0 returns b unchanged.
- Iterative opcodes:
  - 0x13 MULTU: {r2,r} = s*t unsigned, 2*WIDTH-bit product.
  - 0x15 MULT: signed product. Magnitudes are multiplied; the 2*WIDTH product is negated when sign(s) xor sign(t). Most-negative operands handled (e.g. min*min = 2^(2W-2)).
  - 0x16 DIVU: r = s/t, r2 = s%t, unsigned.
- Divide by zero (DIVU, t=0): full WIDTH+1 latency; r = all ones, r2 = s, err=1.
- Invalid opcode (0x05, 0x1A-0x3F): done next cycle, r=0, r2=0, z=1, err=1.
- z is computed from r only, never r2.

Test Plan (WIDTH=32):
- Reset mid-op: rst pulse during cycle 10 of MULTU -> busy=0, done never pulses, r=0, z=1. A following start ADD a=5 b=7 -> done next cycle, r=12.
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=7 -> done at start+33, {r2,r} = 0xFFFFFFFF_FFFFFFEB; also a=b=0x80000000 -> r2=0x40000000, r=0.
- MULTU: a=b=0xFFFFFFFF -> r2=0xFFFFFFFE, r=0x00000001, z=0, busy high for exactly 32 cycles.
- Divide: DIVU a=100 b=7 -> r=14, r2=2, err=0. DIVU a=9 b=0 -> r=0xFFFFFFFF, r2=9, err=1.
- Shifts/edges:
  - SRAV b=0x80000000 with shamt taken from b[4:0]=0 -> r=0x80000000.
  - SRA8 b=0x80000000 -> r=0xFF800000.
  - SUB a=b=0x1234 -> r=0, z=1.
  - BIAS a=b -> r=0, z=1.
- Handshake: start held high continuously with ADD then MULT issued in the done cycle -> second accepted, third start during busy ignored. Invalid opcode 0x3F -> err=1, r=0.
